scs8hd_prbs_chk: RTL and testbench



---
 rtl/scs8hd_prbs_chk.sv | 161 ++++++++++++++++
 tb/tb_scs8hd_prbs_chk.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_prbs_chk.sv
// Serial PRBS checker: self-synchronising LFSR predictor (x^ORDER + x^TAP + 1), lock detect, saturating error count.
// Latency: LOCK, ERR and ERR_CNT are registered; each reflects the beat sampled on the previous CLK edge.
// Backpressure: none; EN qualifies each beat and EN=0 freezes all state (CLR still clears ERR_CNT).
// Optional: define PRBS_CHK_INV_EN to add the INV port, which inverts D before any use.
module scs8hd_prbs_chk #(
  parameter int ORDER       = 7,
  parameter int TAP         = 6,
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             EN,
  input  logic             D,
  input  logic             CLR,
`ifdef PRBS_CHK_INV_EN
  input  logic             INV,
`endif
  output logic             LOCK,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int FILL_W  = $clog2(ORDER + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ORDER-1:0]   sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   cnt_q, cnt_d;

  logic               d_in;
  logic               pred;
  logic               hit;

`ifdef PRBS_CHK_INV_EN
  assign d_in = D ^ INV;
`else
  assign d_in = D;
`endif

  // Predicted next bit from the two feedback taps; a beat "hits" when the data agrees.
  assign pred = sr_q[ORDER-1] ^ sr_q[TAP-1];
  assign hit  = (d_in == pred);

  // Next-state, shift register, counters and output decisions for one enabled beat.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    match_d = match_q;
    loss_d  = loss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (EN) begin
      case (state_q)
        ST_SEED: begin
          sr_d = {sr_q[ORDER-2:0], d_in};
          if (fill_q == FILL_W'(ORDER - 1)) begin
            state_d = ST_ACQ;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        ST_ACQ: begin
          sr_d = {sr_q[ORDER-2:0], d_in};
          // An all-zero register trivially predicts zeros; it must never count toward lock.
          if (hit && (sr_q != '0)) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d = ST_LOCKED;
              match_d = '0;
              loss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end

        ST_LOCKED: begin
          // Free-run on our own prediction so one bad bit costs exactly one error.
          sr_d = {sr_q[ORDER-2:0], pred};
          if (!hit) begin
            err_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (loss_q == LOSS_W'(LOSS_THRESH - 1)) begin
              state_d = ST_SEED;
              fill_d  = '0;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end else begin
            loss_d = '0;
          end
        end

        default: begin
          state_d = ST_SEED;
          fill_d  = '0;
          match_d = '0;
          loss_d  = '0;
        end
      endcase
    end

    // Clear beats a coincident increment; the ERR pulse is unaffected.
    if (CLR) begin
      cnt_d = '0;
    end

    lock_d = (state_d == ST_LOCKED);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= ST_SEED;
      sr_q    <= '0;
      fill_q  <= '0;
      match_q <= '0;
      loss_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      loss_q  <= loss_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LOCK    = lock_q;
  assign ERR     = err_q;
  assign ERR_CNT = cnt_q;

endmodule

// File: tb/tb_scs8hd_prbs_chk.sv
// Bench for scs8hd_prbs_chk: a PRBS7 source with bit-flip injection drives two checkers (16-bit and 4-bit counters).
// Latency: each directed beat pushes its expected outputs, then pops and compares them 1 time unit after the edge.
// Backpressure: none; EN gaps, CLR and asynchronous resets are sequenced directly.
module tb_scs8hd_prbs_chk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        d;
  logic        clr;

  logic        lock0;
  logic        err0;
  logic [15:0] cnt0;
  logic        lock1;
  logic        err1;
  logic [3:0]  cnt1;

  typedef struct packed {
    logic        lock;
    logic        err;
    logic [15:0] cnt;
    logic        lock4;
    logic        err4;
    logic [3:0]  cnt4;
  } obs_t;

  obs_t        sb[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [6:0]  gen = 7'h7F;

  always #5 clk = ~clk;

  scs8hd_prbs_chk u0 (
    .CLK     (clk),
    .RESETB  (rst_n),
    .EN      (en),
    .D       (d),
    .CLR     (clr),
`ifdef PRBS_CHK_INV_EN
    .INV     (1'b0),
`endif
    .LOCK    (lock0),
    .ERR     (err0),
    .ERR_CNT (cnt0)
  );

  scs8hd_prbs_chk #(.ERR_W(4)) u1 (
    .CLK     (clk),
    .RESETB  (rst_n),
    .EN      (en),
    .D       (d),
    .CLR     (clr),
`ifdef PRBS_CHK_INV_EN
    .INV     (1'b0),
`endif
    .LOCK    (lock1),
    .ERR     (err1),
    .ERR_CNT (cnt1)
  );

  // Both checkers see the same stream; the narrow one saturates at 15.
  function automatic obs_t mk(input logic l, input logic e, input int c);
    obs_t r;
    r.lock  = l;
    r.err   = e;
    r.cnt   = 16'(c);
    r.lock4 = l;
    r.err4  = e;
    r.cnt4  = (c > 15) ? 4'd15 : 4'(c);
    return r;
  endfunction

  task automatic check_out();
    obs_t  got;
    obs_t  exp;
    string t;
    got = {lock0, err0, cnt0, lock1, err1, cnt1};
    exp = sb.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed lock=%b err=%b cnt=%0d lock4=%b err4=%b cnt4=%0d, expected lock=%b err=%b cnt=%0d lock4=%b err4=%b cnt4=%0d",
             t, got.lock, got.err, got.cnt, got.lock4, got.err4, got.cnt4,
             exp.lock, exp.err, exp.cnt, exp.lock4, exp.err4, exp.cnt4);
    end
  endtask

  // One beat: drive inputs from the PRBS7 source (optionally flipped or forced to 0), clock once, compare.
  task automatic beat(input string tag, input logic b_en, input logic b_flip, input logic b_clr,
                      input logic b_zero, input logic e_lock, input logic e_err, input int e_cnt);
    logic gbit;
    gbit = gen[6] ^ gen[5];
    en   = b_en;
    clr  = b_clr;
    d    = b_zero ? 1'b0 : (gbit ^ b_flip);
    if (b_en) gen = {gen[5:0], gbit};
    sb.push_back(mk(e_lock, e_err, e_cnt));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Drop reset between edges and check outputs before any clock edge arrives.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 0));
    tag_q.push_back(tag);
    #1;
    check_out();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    d     = 1'b0;
    clr   = 1'b0;

    async_reset("reset_init");

    // Clean acquisition: 7 fill beats + 16 matches, then stays clean.
    for (int k = 1; k <= 508; k++)
      beat("acq", 1'b1, 1'b0, 1'b0, 1'b0, (k >= 23), 1'b0, 0);

    // One isolated flipped bit while locked.
    for (int k = 1; k <= 150; k++)
      beat("single_err", 1'b1, (k == 100), 1'b0, 1'b0, 1'b1, (k == 100), (k >= 100) ? 1 : 0);

    // Clear coincident with an error: count cleared, pulse still fires.
    beat("clr_with_err", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    beat("after_clr",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Eight consecutive errors drop lock on the eighth; count retained through reacquisition.
    for (int k = 1; k <= 8; k++)
      beat("loss", 1'b1, 1'b1, 1'b0, 1'b0, (k < 8), 1'b1, k);
    for (int k = 1; k <= 23; k++)
      beat("relock", 1'b1, 1'b0, 1'b0, 1'b0, (k == 23), 1'b0, 8);
    for (int k = 1; k <= 20; k++)
      beat("relocked", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8);

    // CLR alone, then EN=0 holding state while CLR still acts.
    beat("clr",         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    beat("err_a",       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    beat("en_low_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    beat("en_low_clr",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    beat("err_b",       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    beat("clean",       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    beat("err_c",       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2);

    // Asynchronous reset while locked with ERR high and a nonzero count.
    async_reset("reset_mid_lock");

    // Gapped input: garbage on disabled beats must be ignored; lock after 23 enabled beats.
    for (int k = 1; k <= 46; k++)
      beat("gapped", (k % 2 == 1), (k % 2 == 0), 1'b0, 1'b0, (((k + 1) / 2) >= 23), 1'b0, 0);

    // All-zero stream never locks.
    async_reset("reset_pre_zero");
    for (int k = 1; k <= 200; k++)
      beat("zeros", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Twenty isolated errors: wide counter reaches 20, 4-bit counter saturates at 15.
    async_reset("reset_pre_sat");
    for (int k = 1; k <= 23; k++)
      beat("sat_acq", 1'b1, 1'b0, 1'b0, 1'b0, (k == 23), 1'b0, 0);
    for (int e = 1; e <= 20; e++) begin
      beat("sat_err", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, e);
      for (int j = 1; j <= 4; j++)
        beat("sat_gap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
